// File: rtl/qam_demod.sv
// rtl/qam_demod.sv - coherent 4-QAM/QPSK correlating demodulator with 2-bit re-serialiser
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   en          sample strobe, same strobe that advances the sin/cos LUT
//   sym_sync    first sample of a symbol, qualified by en
//   mixed_in    signed 16-bit received/mixed sample
//   sine_ref    signed 16-bit sine carrier sample
//   cosine_ref  signed 16-bit cosine carrier sample
//   sym_data    decided symbol: [1] sine-channel sign, [0] cosine-channel sign
//   sym_valid   one-cycle pulse when sym_data is updated
//   ser_bit     serialised decision bit, sym_data[1] first
//   ser_valid   qualifies ser_bit
//   locked      high once the first sym_sync has been accepted

module qam_demod #(
  parameter int SPS   = 16,
  parameter int ACC_W = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sym_sync,
  input  logic signed [15:0] mixed_in,
  input  logic signed [15:0] sine_ref,
  input  logic signed [15:0] cosine_ref,
  output logic [1:0]         sym_data,
  output logic               sym_valid,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               locked
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;

  logic signed [31:0]      p_s;
  logic signed [31:0]      p_c;
  logic signed [ACC_W-1:0] p_s_ext;
  logic signed [ACC_W-1:0] p_c_ext;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] sum_c;

  // Control strobes decoded from state and the qualified sample.
  logic start;   // first accepted sync while idle
  logic resync;  // sync mid-symbol: restart the symbol on this sample
  logic last;    // final sample of a symbol: decide on this edge
  logic accum;   // ordinary sample inside a symbol

  // Serialiser: the first bit leaves on the load edge, so only one
  // bit ever waits in the shift register.
  logic [1:0] ser_sr;
  logic       ser_left;

  // Full-precision products; ACC_W >= 32 + clog2(SPS) means a whole
  // symbol of worst-case products cannot overflow the accumulator.
  assign p_s     = mixed_in * sine_ref;
  assign p_c     = mixed_in * cosine_ref;
  assign p_s_ext = {{(ACC_W-32){p_s[31]}}, p_s};
  assign p_c_ext = {{(ACC_W-32){p_c[31]}}, p_c};
  assign sum_s   = acc_s + p_s_ext;
  assign sum_c   = acc_c + p_c_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    resync     = 1'b0;
    last       = 1'b0;
    accum      = 1'b0;
    case (state)
      IDLE: begin
        if (en && sym_sync) begin
          start      = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (en) begin
          if (sym_sync) begin
            resync = 1'b1;
          end else if (cnt == CNT_LAST) begin
            last = 1'b1;
          end else begin
            accum = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Correlators, symbol counter and decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_s     <= '0;
      acc_c     <= '0;
      cnt       <= '0;
      sym_data  <= 2'b00;
      sym_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sym_valid <= last;
      if (start || resync) begin
        acc_s <= p_s_ext;
        acc_c <= p_c_ext;
        cnt   <= CNT_W'(1);
      end else if (last) begin
        // Sign of the completed correlation; an exact zero decides 0.
        sym_data <= {sum_s[ACC_W-1], sum_c[ACC_W-1]};
        acc_s    <= '0;
        acc_c    <= '0;
        cnt      <= '0;
      end else if (accum) begin
        acc_s <= sum_s;
        acc_c <= sum_c;
        cnt   <= cnt + 1'b1;
      end
      if (start) begin
        locked <= 1'b1;
      end
    end
  end

  // Re-serialiser: sym_data[1] then sym_data[0]; a new load always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_sr    <= 2'b00;
      ser_left  <= 1'b0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
    end else if (sym_valid) begin
      ser_bit   <= sym_data[1];
      ser_sr    <= {sym_data[0], 1'b0};
      ser_left  <= 1'b1;
      ser_valid <= 1'b1;
    end else if (ser_left) begin
      ser_bit   <= ser_sr[1];
      ser_sr    <= {ser_sr[0], 1'b0};
      ser_left  <= 1'b0;
      ser_valid <= 1'b1;
    end else begin
      ser_valid <= 1'b0;
    end
  end

endmodule
